inst_decode: RTL and testbench

- RV32I decode stage directly downstream of inst_fetch.
- Registers the fetched PC/INST pair, decodes it into register addresses, a sign-extended immediate, an ALU operation and control flags, and presents one decoded slot to the execute stage.
- Detects load-use hazards against the instruction it currently holds, inserts a bubble, and holds fetch.
- Honours the core-wide stall and a branch flush.

---
 rtl/core_pkg.sv | 92 +++++++++
 rtl/imm_gen.sv | 24 ++
 rtl/inst_decode.sv | 195 +++++++++++++++++++
 tb/tb_inst_decode.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, ALU operation codes and the
// decoded-slot record carried from decode to execute.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // One decoded instruction as handed to execute (valid and PC kept apart).
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        use_imm;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic [2:0]  funct3;
        logic        illegal;
    } dec_slot_t;

    // All-zero slot: no registers, ALU_ADD, no flags.
    localparam dec_slot_t SLOT_EMPTY = '0;

    // ALU operation for OP / OP-IMM; alt selects SUB/SRA where applicable.
    function automatic alu_op_e alu_of(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Immediate format implied by the full 7-bit opcode.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                     fmt = IMM_S;
            OPC_BRANCH:                    fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
            OPC_JAL:                       fmt = IMM_J;
            default:                       fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode
// and returns the sign-extended 32-bit immediate. Purely combinational.
module imm_gen (
    input  logic [31:0] inst,
    output logic [31:0] imm
);
    import core_pkg::*;

    // Assemble the immediate for the format selected by the opcode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        imm = '0;
        case (imm_fmt_of(inst[6:0]))
            IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {inst[31:12], 12'b0};
            IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage. Decodes the fetched instruction combinationally,
// registers one decoded slot for execute, detects load-use hazards against
// the slot it holds, and honours core stall and branch flush.
module inst_decode #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            INST_VALID,
    input  logic [XLEN-1:0] PC,
    input  logic [31:0]     INST,
    output logic            HAZARD,
    output logic            DEC_VALID,
    output logic [XLEN-1:0] DEC_PC,
    output logic [4:0]      RS1_ADDR,
    output logic [4:0]      RS2_ADDR,
    output logic [4:0]      RD_ADDR,
    output logic [31:0]     IMM,
    output logic [3:0]      ALU_OP,
    output logic            USE_IMM,
    output logic            IS_LOAD,
    output logic            IS_STORE,
    output logic            IS_BRANCH,
    output logic            IS_JAL,
    output logic            IS_JALR,
    output logic [2:0]      MEM_FUNCT3,
    output logic            ILLEGAL
);
    import core_pkg::*;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [4:0]  rd_f;
    logic [31:0] imm;
    logic        op_funct7_ok;
    logic        opimm_funct7_ok;

    dec_slot_t       dec;
    dec_slot_t       slot;
    logic            dec_valid;
    logic [XLEN-1:0] dec_pc;

    assign opcode = INST[6:0];
    assign rd_f   = INST[11:7];
    assign funct3 = INST[14:12];
    assign rs1_f  = INST[19:15];
    assign rs2_f  = INST[24:20];
    assign funct7 = INST[31:25];

    // R-type accepts funct7 0, or 0100000 only for SUB and SRA.
    assign op_funct7_ok = (funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    // OP-IMM shifts carry funct7 in the immediate field; other OP-IMM ops do not.
    assign opimm_funct7_ok = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                             (funct3 == 3'b101) ? ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) :
                             1'b1;

    imm_gen u_imm_gen (
        .inst (INST),
        .imm  (imm)
    );

    // Decode the incoming instruction; unused register fields stay zero.
    always_comb begin
        dec = SLOT_EMPTY;
        case (opcode)
            OPC_LOAD: begin
                dec.rs1     = rs1_f;
                dec.rd      = rd_f;
                dec.imm     = imm;
                dec.use_imm = 1'b1;
                dec.is_load = 1'b1;
                dec.funct3  = funct3;
            end
            OPC_STORE: begin
                dec.rs1      = rs1_f;
                dec.rs2      = rs2_f;
                dec.imm      = imm;
                dec.use_imm  = 1'b1;
                dec.is_store = 1'b1;
                dec.funct3   = funct3;
            end
            OPC_BRANCH: begin
                dec.rs1       = rs1_f;
                dec.rs2       = rs2_f;
                dec.imm       = imm;
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.funct3    = funct3;
            end
            OPC_OP: begin
                dec.rs1     = rs1_f;
                dec.rs2     = rs2_f;
                dec.rd      = rd_f;
                dec.alu_op  = alu_of(funct3, funct7[5]);
                dec.illegal = !op_funct7_ok;
            end
            OPC_OPIMM: begin
                dec.rs1     = rs1_f;
                dec.rd      = rd_f;
                dec.imm     = imm;
                dec.use_imm = 1'b1;
                dec.alu_op  = alu_of(funct3, (funct3 == 3'b101) && funct7[5]);
                dec.illegal = !opimm_funct7_ok;
            end
            OPC_LUI: begin
                dec.rd      = rd_f;
                dec.imm     = imm;
                dec.use_imm = 1'b1;
                dec.alu_op  = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec.rd      = rd_f;
                dec.imm     = imm;
                dec.use_imm = 1'b1;
            end
            OPC_JAL: begin
                dec.rd      = rd_f;
                dec.imm     = imm;
                dec.use_imm = 1'b1;
                dec.is_jal  = 1'b1;
            end
            OPC_JALR: begin
                dec.rs1     = rs1_f;
                dec.rd      = rd_f;
                dec.imm     = imm;
                dec.use_imm = 1'b1;
                dec.is_jalr = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // FENCE and SYSTEM retire as a NOP: ADD with no write-back.
                dec = SLOT_EMPTY;
            end
            default: dec.illegal = 1'b1;
        endcase

        // An illegal slot carries no operands, no write-back and no class flags.
        if (dec.illegal) begin
            dec         = SLOT_EMPTY;
            dec.illegal = 1'b1;
        end
    end

    // Load-use: the held load writes a register the incoming instruction reads.
    // Unused source fields are zero and rd is non-zero, so they never match.
    assign HAZARD = dec_valid && slot.is_load && INST_VALID && (slot.rd != 5'd0) &&
                    ((dec.rs1 == slot.rd) || (dec.rs2 == slot.rd));

    // Pipeline register: flush > stall > hazard bubble > capture > bubble.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!RST) begin
            dec_valid <= 1'b0;
            dec_pc    <= RESET_PC;
            slot      <= SLOT_EMPTY;
        end else if (FLUSH) begin
            dec_valid <= 1'b0;
            slot      <= SLOT_EMPTY;
        end else if (!STALL) begin
            if (HAZARD || !INST_VALID) begin
                dec_valid <= 1'b0;
                slot      <= SLOT_EMPTY;
            end else begin
                dec_valid <= 1'b1;
                dec_pc    <= PC;
                slot      <= dec;
            end
        end
    end

    assign DEC_VALID  = dec_valid;
    assign DEC_PC     = dec_pc;
    assign RS1_ADDR   = slot.rs1;
    assign RS2_ADDR   = slot.rs2;
    assign RD_ADDR    = slot.rd;
    assign IMM        = slot.imm;
    assign ALU_OP     = slot.alu_op;
    assign USE_IMM    = slot.use_imm;
    assign IS_LOAD    = slot.is_load;
    assign IS_STORE   = slot.is_store;
    assign IS_BRANCH  = slot.is_branch;
    assign IS_JAL     = slot.is_jal;
    assign IS_JALR    = slot.is_jalr;
    assign MEM_FUNCT3 = slot.funct3;
    assign ILLEGAL    = slot.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// Testbench for inst_decode: directed scenarios plus a randomized run
// against a behavioural decode/pipeline model.
module tb_inst_decode;
    import core_pkg::*;

    logic        CLK;
    logic        RST;
    logic        STALL;
    logic        FLUSH;
    logic        INST_VALID;
    logic [31:0] PC;
    logic [31:0] INST;
    logic        HAZARD;
    logic        DEC_VALID;
    logic [31:0] DEC_PC;
    logic [4:0]  RS1_ADDR;
    logic [4:0]  RS2_ADDR;
    logic [4:0]  RD_ADDR;
    logic [31:0] IMM;
    logic [3:0]  ALU_OP;
    logic        USE_IMM;
    logic        IS_LOAD;
    logic        IS_STORE;
    logic        IS_BRANCH;
    logic        IS_JAL;
    logic        IS_JALR;
    logic [2:0]  MEM_FUNCT3;
    logic        ILLEGAL;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        use_imm;
        logic        ld;
        logic        st;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic        ill;
    } slot_t;

    inst_decode #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .STALL      (STALL),
        .FLUSH      (FLUSH),
        .INST_VALID (INST_VALID),
        .PC         (PC),
        .INST       (INST),
        .HAZARD     (HAZARD),
        .DEC_VALID  (DEC_VALID),
        .DEC_PC     (DEC_PC),
        .RS1_ADDR   (RS1_ADDR),
        .RS2_ADDR   (RS2_ADDR),
        .RD_ADDR    (RD_ADDR),
        .IMM        (IMM),
        .ALU_OP     (ALU_OP),
        .USE_IMM    (USE_IMM),
        .IS_LOAD    (IS_LOAD),
        .IS_STORE   (IS_STORE),
        .IS_BRANCH  (IS_BRANCH),
        .IS_JAL     (IS_JAL),
        .IS_JALR    (IS_JALR),
        .MEM_FUNCT3 (MEM_FUNCT3),
        .ILLEGAL    (ILLEGAL)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    function automatic slot_t got();
        slot_t s;
        s.valid   = DEC_VALID;
        s.rs1     = RS1_ADDR;
        s.rs2     = RS2_ADDR;
        s.rd      = RD_ADDR;
        s.imm     = IMM;
        s.alu     = ALU_OP;
        s.use_imm = USE_IMM;
        s.ld      = IS_LOAD;
        s.st      = IS_STORE;
        s.br      = IS_BRANCH;
        s.jal     = IS_JAL;
        s.jalr    = IS_JALR;
        s.f3      = MEM_FUNCT3;
        s.ill     = ILLEGAL;
        return s;
    endfunction

    // Reference decode written from the ISA rules with plain integer arithmetic.
    function automatic slot_t model(input logic [31:0] i);
        slot_t       s;
        int          si;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [3:0]  alu_tbl [8];
        logic        bad;
        s   = '0;
        si  = int'(i);
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        alu_tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        imm_i = 32'(si >>> 20);
        imm_s = 32'((si >>> 25) * 32) + 32'(i[11:7]);
        imm_b = 32'((si >>> 31) * 4096) + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
        imm_u = i & 32'hFFFF_F000;
        imm_j = 32'((si >>> 31) * 1048576) + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
        bad = 1'b0;
        s.valid = 1'b1;
        s.alu   = ALU_ADD;
        case (opc)
            7'b0000011: begin s.rs1 = i[19:15]; s.rd = i[11:7]; s.imm = imm_i; s.use_imm = 1; s.ld = 1; s.f3 = f3; end
            7'b0100011: begin s.rs1 = i[19:15]; s.rs2 = i[24:20]; s.imm = imm_s; s.use_imm = 1; s.st = 1; s.f3 = f3; end
            7'b1100011: begin s.rs1 = i[19:15]; s.rs2 = i[24:20]; s.imm = imm_b; s.br = 1; s.f3 = f3; s.alu = ALU_SUB; end
            7'b0110011: begin
                s.rs1 = i[19:15]; s.rs2 = i[24:20]; s.rd = i[11:7];
                s.alu = alu_tbl[f3];
                if (f7 == 7'h20 && f3 == 3'd0) s.alu = ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) s.alu = ALU_SRA;
                else if (f7 != 7'h00) bad = 1;
            end
            7'b0010011: begin
                s.rs1 = i[19:15]; s.rd = i[11:7]; s.imm = imm_i; s.use_imm = 1;
                s.alu = alu_tbl[f3];
                if (f3 == 3'd5 && f7 == 7'h20) s.alu = ALU_SRA;
                else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) bad = 1;
            end
            7'b0110111: begin s.rd = i[11:7]; s.imm = imm_u; s.use_imm = 1; s.alu = ALU_PASSB; end
            7'b0010111: begin s.rd = i[11:7]; s.imm = imm_u; s.use_imm = 1; end
            7'b1101111: begin s.rd = i[11:7]; s.imm = imm_j; s.use_imm = 1; s.jal = 1; end
            7'b1100111: begin s.rs1 = i[19:15]; s.rd = i[11:7]; s.imm = imm_i; s.use_imm = 1; s.jalr = 1; end
            7'b0001111, 7'b1110011: ;
            default: bad = 1;
        endcase
        if (bad) begin
            s = '0; s.valid = 1; s.ill = 1;
        end
        return s;
    endfunction

    // Random legal instruction with registers x0..x3 so load-use pairs are common.
    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rs1, rs2, rd;
        r   = $urandom;
        f3  = r[14:12];
        f7  = r[31:25];
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0, 9: opc = OPC_LOAD;
            1: opc = OPC_STORE;
            2: opc = OPC_BRANCH;
            3: begin opc = OPC_OP; f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00; end
            4: begin
                opc = OPC_OPIMM;
                if (f3 == 3'd1) f7 = 7'h00;
                else if (f3 == 3'd5) f7 = r[30] ? 7'h20 : 7'h00;
            end
            5: opc = OPC_LUI;
            6: opc = OPC_AUIPC;
            7: opc = OPC_JAL;
            default: opc = OPC_JALR;
        endcase
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst);
        INST_VALID = iv;
        PC         = pc;
        INST       = inst;
    endtask

    task automatic test_reset;
        slot_t obs;
        RST = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #5;
        obs = got();
        checks++;
        if (obs !== slot_t'('0)) begin
            errors++; $display("FAIL reset_fields: got %h expected %h", obs, slot_t'('0));
        end
        checks++;
        if (DEC_PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", DEC_PC); end
        checks++;
        if (HAZARD !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", HAZARD); end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_addi;
        slot_t e, obs;
        drive(1'b1, 32'h10, 32'h0050_0093);
        @(negedge CLK);
        e = '0; e.valid = 1; e.rd = 5'd1; e.imm = 32'd5; e.alu = ALU_ADD; e.use_imm = 1;
        obs = got();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL addi_fields: got %h expected %h", obs, e); end
        checks++;
        if (DEC_PC !== 32'h10) begin errors++; $display("FAIL addi_pc: got %h expected 10", DEC_PC); end
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 32'h14, 32'h0050_0093);
        @(posedge CLK);
        #3;
        checks++;
        if (DEC_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", DEC_VALID); end
        RST = 1'b0;
        #1;
        checks++;
        if (DEC_VALID !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", DEC_VALID); end
        checks++;
        if (DEC_PC !== 32'h0) begin errors++; $display("FAIL mid_reset_pc: got %h expected 0", DEC_PC); end
        @(negedge CLK);
        RST = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_load_use;
        slot_t e, obs;
        drive(1'b1, 32'h20, 32'h0000_A103);
        @(negedge CLK);
        e = '0; e.valid = 1; e.rs1 = 5'd1; e.rd = 5'd2; e.use_imm = 1; e.ld = 1; e.f3 = 3'd2;
        obs = got();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lw_fields: got %h expected %h", obs, e); end
        drive(1'b1, 32'h24, 32'h0011_01B3);
        #1;
        checks++;
        if (HAZARD !== 1'b1) begin errors++; $display("FAIL lu_hazard: got %b expected 1", HAZARD); end
        @(negedge CLK);
        checks++;
        if (DEC_VALID !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", DEC_VALID); end
        #1;
        checks++;
        if (HAZARD !== 1'b0) begin errors++; $display("FAIL lu_hazard_drop: got %b expected 0", HAZARD); end
        @(negedge CLK);
        e = '0; e.valid = 1; e.rs1 = 5'd2; e.rs2 = 5'd1; e.rd = 5'd3; e.alu = ALU_ADD;
        obs = got();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lu_add_fields: got %h expected %h", obs, e); end
        checks++;
        if (DEC_PC !== 32'h24) begin errors++; $display("FAIL lu_add_pc: got %h expected 24", DEC_PC); end
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_branch_stall;
        slot_t e, obs;
        drive(1'b1, 32'h30, 32'hFE00_0EE3);
        @(negedge CLK);
        e = '0; e.valid = 1; e.imm = 32'hFFFF_FFFC; e.br = 1; e.alu = ALU_SUB;
        obs = got();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL beq_fields: got %h expected %h", obs, e); end
        STALL = 1'b1;
        drive(1'b1, 32'h34, 32'h0050_0093);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            obs = got();
            checks++;
            if (obs !== e || DEC_PC !== 32'h30) begin
                errors++; $display("FAIL stall_hold_%0d: got %h pc %h expected %h pc 30", k, obs, DEC_PC, e);
            end
        end
        STALL = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_flush_illegal;
        drive(1'b1, 32'h40, 32'h0050_0093);
        @(negedge CLK);
        FLUSH = 1'b1; STALL = 1'b1;
        drive(1'b1, 32'h44, 32'h0050_0093);
        @(negedge CLK);
        checks++;
        if (DEC_VALID !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", DEC_VALID); end
        FLUSH = 1'b0; STALL = 1'b0;
        drive(1'b1, 32'h48, 32'h0000_0000);
        @(negedge CLK);
        checks++;
        if ({DEC_VALID, ILLEGAL, RD_ADDR} !== {1'b1, 1'b1, 5'd0}) begin
            errors++; $display("FAIL zero_inst: got v%b ill%b rd%0d expected v1 ill1 rd0", DEC_VALID, ILLEGAL, RD_ADDR);
        end
        drive(1'b1, 32'h4C, 32'h0000_000F);
        @(negedge CLK);
        checks++;
        if ({DEC_VALID, ILLEGAL, RD_ADDR, ALU_OP} !== {1'b1, 1'b0, 5'd0, 4'(ALU_ADD)}) begin
            errors++; $display("FAIL fence_nop: got v%b ill%b rd%0d alu%0d expected v1 ill0 rd0 alu0", DEC_VALID, ILLEGAL, RD_ADDR, ALU_OP);
        end
        drive(1'b1, 32'h50, 32'h4000_11B3);
        @(negedge CLK);
        checks++;
        if ({DEC_VALID, ILLEGAL, RD_ADDR} !== {1'b1, 1'b1, 5'd0}) begin
            errors++; $display("FAIL bad_funct7: got v%b ill%b rd%0d expected v1 ill1 rd0", DEC_VALID, ILLEGAL, RD_ADDR);
        end
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_random;
        slot_t       m, e, obs;
        logic [31:0] mpc, cpc, ci, next_pc;
        logic        civ, st, fl, hz, held;
        m = '0; mpc = '0; cpc = '0; ci = '0; civ = 1'b0; held = 1'b0;
        next_pc = 32'h100;
        for (int c = 0; c < 600; c++) begin
            obs = got();
            checks++;
            if (m.valid ? (obs !== m || DEC_PC !== mpc) : (DEC_VALID !== 1'b0)) begin
                errors++; $display("FAIL rand_slot_%0d: got %h pc %h expected %h pc %h", c, obs, DEC_PC, m, mpc);
            end
            if (!held) begin
                civ = ($urandom_range(0, 9) < 7);
                ci  = rand_inst();
                cpc = next_pc;
                next_pc += 32'd4;
            end
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 11) == 0);
            STALL = st; FLUSH = fl;
            drive(civ, cpc, ci);
            #1;
            e  = model(ci);
            hz = m.valid && m.ld && civ && (m.rd != 5'd0) && ((e.rs1 == m.rd) || (e.rs2 == m.rd));
            checks++;
            if (HAZARD !== hz) begin
                errors++; $display("FAIL rand_hazard_%0d: got %b expected %b inst %h", c, HAZARD, hz, ci);
            end
            if (fl) m = '0;
            else if (!st) begin
                if (hz || !civ) m = '0;
                else begin m = e; mpc = cpc; end
            end
            held = !fl && civ && (st || hz);
            @(negedge CLK);
        end
        STALL = 1'b0; FLUSH = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_reset_mid();
        test_load_use();
        test_branch_stall();
        test_flush_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
